// File: rtl/audio_pkg.sv
// Shared types and default constants for the PDM capture datapath.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } pdm_state_t;

  localparam int unsigned PDM_CLK_DIV        = 50;
  localparam int unsigned PDM_DECIMATION     = 128;
  localparam int unsigned PDM_SAMPLE_W       = 8;
  localparam int unsigned PDM_SETTLE_SAMPLES = 4;

  // Width needed to hold a ones-count of 0..dec inclusive.
  function automatic int unsigned pdm_cnt_w(input int unsigned dec);
    return $clog2(dec + 1);
  endfunction

endpackage

// File: rtl/pdm_clock_gen.sv
// Mic clock divider: 50% duty micClock and a one-cycle sample strobe at the
// last system clock of the low phase. Counter is held at 0 when not running
// or when cleared.
module pdm_clock_gen
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV = PDM_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic mic_clk,
  output logic strobe
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  // Next divider count: wrap at CLK_DIV-1, forced to 0 when idle or cleared.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!run || clear) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign mic_clk = run && (div_cnt_q < DIV_HALF);
  assign strobe  = run && (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/pdm_sample_capture.sv
// PDM microphone capture: drives micClock, synchronizes audioIn, decimates by
// ones-counting over DECIMATION mic bits and emits one PCM sample per window
// with a one-cycle done strobe.
// Optional feature: define PDM_CENTER_EN for signed (mid-scale removed) PCM.
module pdm_sample_capture
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV        = PDM_CLK_DIV,
  parameter int unsigned DECIMATION     = PDM_DECIMATION,
  parameter int unsigned SAMPLE_W       = PDM_SAMPLE_W,
  parameter int unsigned SETTLE_SAMPLES = PDM_SETTLE_SAMPLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                audioIn,
  output logic                micClock,
  output logic                LR_sel,
  output logic [SAMPLE_W-1:0] dataOut,
  output logic                done,
  output logic                busy
);

  localparam int unsigned CNT_W    = pdm_cnt_w(DECIMATION);
  localparam int unsigned BIT_W    = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int unsigned SET_W    = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam int unsigned SET_LAST = (SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DECIMATION - 1);
  localparam logic [SET_W-1:0] SET_END  = SET_W'(SET_LAST);

  pdm_state_t          state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt;
  logic                strobe;

  assign busy = (state_q != IDLE);

  pdm_clock_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clock_gen (
    .clock   (clock),
    .reset   (reset),
    .run     (busy),
    .clear   (~enable),
    .mic_clk (micClock),
    .strobe  (strobe)
  );

  // Two-flop synchronizer for the asynchronous mic data pin.
  always_comb begin
    sync1_d = audioIn;
    sync2_d = sync1_q;
  end

  // FSM, ones-count accumulator and PCM output selection.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    settle_d  = settle_q;
    data_d    = data_q;
    done_d    = 1'b0;
    cnt       = '0;
    if (state_q == IDLE) begin
      acc_d     = '0;
      bit_cnt_d = '0;
      settle_d  = '0;
      if (enable) begin
        state_d = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
      end
    end else if (!enable) begin
      state_d   = IDLE;
      acc_d     = '0;
      bit_cnt_d = '0;
      settle_d  = '0;
    end else if (strobe) begin
      if (bit_cnt_q == BIT_LAST) begin
        // Final bit folds straight into the result so the next window
        // starts clean on the same edge without dropping a mic bit.
        cnt       = acc_q + CNT_W'(sync2_q);
        acc_d     = '0;
        bit_cnt_d = '0;
        if (state_q == SETTLE) begin
          if (settle_q == SET_END) begin
            settle_d = '0;
            state_d  = RUN;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end else begin
`ifdef PDM_CENTER_EN
          data_d = SAMPLE_W'(cnt) - SAMPLE_W'(DECIMATION / 2);
`else
          data_d = SAMPLE_W'(cnt);
`endif
          done_d = 1'b1;
        end
      end else begin
        acc_d     = acc_q + CNT_W'(sync2_q);
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
      settle_q  <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      settle_q  <= settle_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign dataOut = data_q;
  assign done    = done_q;
  assign LR_sel  = 1'b0;

endmodule
